// File: rtl/ca_rule_sequencer.sv
// ca_rule_sequencer: per-row CA rule/colour sequencing, scrolling and reseed.
// Build option: define CA_CUSTOM_RULE_EN to make rule-table entry 7 loadable.
module ca_rule_sequencer #(
   parameter int ROWS_PER_FRAME = 120,
   parameter int BAND_LOG2      = 8,
   parameter int CNT_W          = 11
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic       row_tick,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       btn_pause,
   input  logic       btn_reseed,
   input  logic [7:0] cfg_rule,
   input  logic       cfg_load,
   output logic [7:0] rule,
   output logic [5:0] rule_color,
   output logic [2:0] rule_idx,
   output logic       seed_req,
   output logic       paused
);

   typedef enum logic [1:0] {WAIT, SEED, RUN} state_t;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam int unused_rows = ROWS_PER_FRAME;

   state_t           state_q;
   state_t           state_d;
   logic             reseed_pend;
   logic             consume;
   logic             fb_clr;
   logic             fb_inc;
   logic [CNT_W-1:0] frame_base;
   logic [CNT_W-1:0] row_cnt;
   logic [2:0]       offset;
   logic [3:0]       btn_s1;
   logic [3:0]       btn_s2;
   logic [3:0]       btn_s3;
   logic [3:0]       edges;
   logic [2:0]       idx;
   logic [7:0]       rule_d;
   logic [7:0]       rule7;

   // bit order: {reseed, pause, prev, next}
   assign edges = btn_s2 & ~btn_s3;

`ifdef CA_CUSTOM_RULE_EN
   // loadable table entry 7
   always_ff @(posedge clk) begin
      if (!rst_n)
         rule7 <= 8'd146;
      else if (cfg_load)
         rule7 <= cfg_rule;
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{cfg_rule, cfg_load};
   assign rule7 = 8'd146;
`endif

   // two-flop synchronizers plus the delayed copy for edge detect
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
         btn_s3 <= '0;
      end else begin
         btn_s1 <= {btn_reseed, btn_pause, btn_prev, btn_next};
         btn_s2 <= btn_s1;
         btn_s3 <= btn_s2;
      end
   end

   // manual rule offset and scroll-freeze flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         offset <= 3'd0;
         paused <= 1'b0;
      end else begin
         if (edges[0] && !edges[1])
            offset <= offset + 3'd1;
         else if (edges[1] && !edges[0])
            offset <= offset - 3'd1;
         if (edges[2])
            paused <= ~paused;
      end
   end

   // next-state: frame strobes drive seeding and scroll decisions
   always_comb begin
      state_d = state_q;
      consume = 1'b0;
      fb_clr  = 1'b0;
      fb_inc  = 1'b0;
      if (frame_start) begin
         case (state_q)
            WAIT: begin
               state_d = SEED;
               fb_clr  = 1'b1;
            end
            SEED: begin
               if (reseed_pend)
                  consume = 1'b1;
               else
                  state_d = RUN;
            end
            RUN: begin
               if (reseed_pend) begin
                  state_d = SEED;
                  consume = 1'b1;
                  fb_clr  = 1'b1;
               end else if (!paused) begin
                  fb_inc = 1'b1;
               end
            end
            default: state_d = WAIT;
         endcase
      end
   end

   // state, reseed request, frame base and row counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= WAIT;
         seed_req    <= 1'b0;
         reseed_pend <= 1'b0;
         frame_base  <= '0;
         row_cnt     <= '0;
      end else begin
         state_q  <= state_d;
         seed_req <= (state_d == SEED);
         // a new press wins over consumption so it is never lost
         if (edges[3])
            reseed_pend <= 1'b1;
         else if (consume)
            reseed_pend <= 1'b0;
         if (fb_clr)
            frame_base <= '0;
         else if (fb_inc)
            frame_base <= frame_base + ONE;
         if (frame_start)
            row_cnt <= frame_base;
         else if (row_tick)
            row_cnt <= row_cnt + ONE;
      end
   end

   assign idx = row_cnt[CNT_W-1:BAND_LOG2] + offset;

   // rule table lookup
   always_comb begin
      rule_d = rule7;
      case (idx)
         3'd0:    rule_d = 8'd30;
         3'd1:    rule_d = 8'd110;
         3'd2:    rule_d = 8'd22;
         3'd3:    rule_d = 8'd60;
         3'd4:    rule_d = 8'd118;
         3'd5:    rule_d = 8'd161;
         3'd6:    rule_d = 8'd90;
         default: rule_d = rule7;
      endcase
   end

   // registered outputs, frozen at reset values until the first frame
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rule       <= 8'd30;
         rule_color <= 6'b011001;
         rule_idx   <= 3'd0;
      end else if (state_q != WAIT) begin
         rule       <= rule_d;
         rule_color <= {idx[0], 2'b11, idx[1], idx[2], 1'b1};
         rule_idx   <= idx;
      end
   end

endmodule
